// File: rtl/branch_pkg.sv
// Shared branch encodings: func3 condition codes, instruction size and the
// resolve-unit state encoding.
package branch_pkg;

   localparam int INSN_BYTES = 4;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

endpackage

// File: rtl/fast_comparator.sv
// Branch condition evaluator for one func3 code; purely combinational,
// no handshake.
module fast_comparator
   import branch_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       func3,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             cond
);

   logic eq;
   logic lt_u;
   logic lt_s;

   assign eq   = (a == b);
   assign lt_u = (a < b);
   // Signed order reuses the unsigned compare unless the sign bits differ.
   assign lt_s = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : lt_u;

   always_comb begin
      cond = 1'b0;
      case (func3)
         F3_BEQ:  cond = eq;
         F3_BNE:  cond = !eq;
         F3_BLT:  cond = lt_s;
         F3_BGE:  cond = !lt_s;
         F3_BLTU: cond = lt_u;
         F3_BGEU: cond = !lt_u;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps one cycle after accept and raises a fetch redirect on
// mispredict; in_ready stays low until the redirect is taken by fetch.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 is_jal,
   input  logic                 is_jalr,
   input  logic [2:0]           func3,
   input  logic [WIDTH-1:0]     data1,
   input  logic [WIDTH-1:0]     data2,
   input  logic [WIDTH-1:0]     pc,
   input  logic [WIDTH-1:0]     imm,
   input  logic                 pred_taken,
   input  logic [WIDTH-1:0]     pred_target,
   output logic                 res_valid,
   output logic                 res_taken,
   output logic [WIDTH-1:0]     res_target,
   output logic [WIDTH-1:0]     res_link,
   output logic                 redirect_valid,
   input  logic                 redirect_ready,
   output logic [WIDTH-1:0]     redirect_pc,
   output logic                 flush,
   output logic [CNT_WIDTH-1:0] branch_cnt,
   output logic [CNT_WIDTH-1:0] mispredict_cnt
);

   logic [0:0]       state;
   logic             accept;
   logic             cond;
   logic             taken;
   logic             mispredict;
   logic [WIDTH-1:0] jalr_sum;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] link;
   logic [WIDTH-1:0] next_pc;

   fast_comparator #(.WIDTH(WIDTH)) u_cmp (
      .func3 (func3),
      .a     (data1),
      .b     (data2),
      .cond  (cond)
   );

   assign in_ready   = (state == ST_IDLE);
   assign accept     = in_valid && in_ready;
   assign taken      = is_jal || is_jalr || cond;
   assign jalr_sum   = data1 + imm;
   assign target     = is_jalr ? {jalr_sum[WIDTH-1:1], 1'b0} : (pc + imm);
   assign link       = pc + WIDTH'(INSN_BYTES);
   assign next_pc    = taken ? target : link;
   // A not-taken prediction carries no meaningful target, so only compare it when taken.
   assign mispredict = (taken != pred_taken) || (taken && (target != pred_target));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid  <= 1'b0;
         res_taken  <= 1'b0;
         res_target <= '0;
         res_link   <= '0;
         flush      <= 1'b0;
      end else begin
         res_valid <= accept;
         flush     <= accept && mispredict;
         if (accept) begin
            res_taken  <= taken;
            res_target <= target;
            res_link   <= link;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && mispredict) begin
                  state          <= ST_REDIRECT;
                  redirect_valid <= 1'b1;
                  redirect_pc    <= next_pc;
               end
            end
            ST_REDIRECT: begin
               if (redirect_ready) begin
                  state          <= ST_IDLE;
                  redirect_valid <= 1'b0;
               end
            end
            default: begin
               state          <= ST_IDLE;
               redirect_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         if (accept && (branch_cnt != '1))
            branch_cnt <= branch_cnt + CNT_WIDTH'(1);
         if (accept && mispredict && (mispredict_cnt != '1))
            mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and PC width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, giving the statistics counter width.
REQ-003 SHALL have ports `clk` (in, 1) as the single clock and `rst_n` (in, 1) as the reset; reset is asynchronous and active-low.
REQ-004 SHALL have port `in_valid` (in, 1): a control-flow instruction is offered.
REQ-005 SHALL have port `in_ready` (out, 1): the unit can accept an instruction.
REQ-006 SHALL have ports `is_jal` (in, 1) and `is_jalr` (in, 1): unconditional jump type; both low means a conditional branch.
REQ-007 SHALL have port `func3` (in, 3): branch condition code.
REQ-008 SHALL have ports `data1` and `data2` (in, WIDTH): forwarded rs1 and rs2 values.
REQ-009 SHALL have ports `pc` (in, WIDTH) and `imm` (in, WIDTH): instruction PC and sign-extended offset.
REQ-010 SHALL have ports `pred_taken` (in, 1) and `pred_target` (in, WIDTH): the fetch-stage prediction.
REQ-011 SHALL have ports `res_valid` (out, 1), `res_taken` (out, 1), `res_target` (out, WIDTH) and `res_link` (out, WIDTH): the resolved outcome.
REQ-012 SHALL have ports `redirect_valid` (out, 1), `redirect_ready` (in, 1) and `redirect_pc` (out, WIDTH): the fetch redirect handshake.
REQ-013 SHALL have port `flush` (out, 1): kill pulse to the younger pipeline stages.
REQ-014 SHALL have ports `branch_cnt` and `mispredict_cnt` (out, CNT_WIDTH): statistics counters.

Function
REQ-015 SHALL accept an instruction in a cycle where in_valid and in_ready are both high.
REQ-016 SHALL implement two states, IDLE and REDIRECT; in_ready SHALL equal (state==IDLE).
REQ-017 SHALL evaluate conditions per func3:
- 000 BEQ, 001 BNE
- 100 BLT, 101 BGE (signed)
- 110 BLTU, 111 BGEU (unsigned)
- 010 and 011 SHALL resolve not-taken.
REQ-018 SHALL treat is_jal or is_jalr as taken regardless of func3; is_jalr SHALL take precedence when both are set.
REQ-019 SHALL compute the target modulo 2^WIDTH as:
- jalr: (data1+imm) with bit 0 cleared
- otherwise: pc+imm
REQ-020 SHALL compute link = pc+4 and next = taken ? target : pc+4, both wrapping modulo 2^WIDTH.
REQ-021 SHALL flag a mispredict when taken!=pred_taken, or when taken and target!=pred_target; pred_target SHALL be ignored when not taken.
REQ-022 SHALL, in the cycle after acceptance, hold res_valid=1 for exactly one cycle with res_taken, res_target and res_link registered (latency 1).
REQ-023 SHALL, on mispredict, in that same cycle: pulse flush high for one cycle, raise redirect_valid with redirect_pc=next, and move to REDIRECT.
REQ-024 SHALL hold redirect_valid and redirect_pc stable while in REDIRECT until redirect_ready is high, then return to IDLE; in_ready SHALL rise in the following cycle.
REQ-025 SHALL complete the redirect handshake in the first redirect_valid cycle if redirect_ready is already high in that cycle.
REQ-026 SHALL remain in IDLE on a correct prediction, keeping in_ready high so back-to-back accepts are possible.
REQ-027 SHALL ignore in_valid while in REDIRECT; upstream holds the instruction.
REQ-028 SHALL increment branch_cnt on every accept and mispredict_cnt on every mispredict; both SHALL saturate at all-ones.
REQ-029 SHALL hold flush low at all times other than the REQ-023 pulse.

Reset
REQ-030 SHALL on rst_n low asynchronously set: state IDLE, res_valid 0, redirect_valid 0, flush 0, res_taken 0, res_target 0, res_link 0, redirect_pc 0, both counters 0.
REQ-031 SHALL drop a pending redirect when reset asserts mid-REDIRECT; after release, in_ready SHALL be 1 in the first clock.

Structure
REQ-032 SHALL obtain func3 codes (BEQ..BGEU), INSN_BYTES=4 and the state encoding from shared package branch_pkg.
REQ-033 SHALL instantiate the codebase's fast_comparator as its single sub-module for condition evaluation; no duplicate comparator logic.

Verification
REQ-034 SHALL cover: BLT, data1=0xFFFFFFFF, data2=1, pc=0x100, imm=0x20, pred_taken=0 -> res_taken=1, flush pulse, redirect_pc=0x120, mispredict_cnt=1.
REQ-035 SHALL cover: BLTU with the same operands, pred_taken=0 -> not taken, no flush, res_link=0x104, in_ready stays 1.
REQ-036 SHALL cover: JALR, data1=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 -> target 0x1004, no mispredict.
REQ-037 SHALL cover: mispredict with redirect_ready low for 3 cycles -> redirect_pc stable, in_ready=0 for 4 cycles, in_valid ignored.
REQ-038 SHALL cover: pc=0xFFFFFFFC, BEQ taken with imm=8 -> target 0x00000004 (wrap); func3=010 -> not taken.
REQ-039 SHALL cover: rst_n low mid-REDIRECT -> redirect_valid=0 immediately; CNT_WIDTH=2 with 5 mispredicts -> mispredict_cnt=3.
